// File: rtl/line_buffer_window.sv
// line_buffer_window: streaming 3x3 window generator for the Scharr stage.
// Pixels arrive in raster order into four rotating line buffers. Once three
// full lines are held, one 3x3 window per cycle is emitted for the oldest
// three lines, then the oldest buffer is freed with a one-cycle line-done pulse.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pixel_data[7:0]     input pixel, raster order
//   i_pixel_data_valid    pixel accepted this cycle (no backpressure)
//   o_window_data[71:0]   window; byte k = 3*row + col at bits [8k+:8]
//   o_window_valid        o_window_data valid this cycle
//   o_line_done           pulse on the last window of an output line
//   o_fill_level          pixels stored and not yet freed
module line_buffer_window #(
    parameter int unsigned P_IMG_WIDTH = 512,
    parameter int unsigned P_CNT_W     = $clog2(4 * P_IMG_WIDTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_pixel_data,
    input  logic               i_pixel_data_valid,
    output logic [71:0]        o_window_data,
    output logic               o_window_valid,
    output logic               o_line_done,
    output logic [P_CNT_W-1:0] o_fill_level
);

    localparam int unsigned COL_W = $clog2(P_IMG_WIDTH);
    localparam int unsigned NBUF  = 4;

    localparam logic [COL_W-1:0]   LAST_WCOL  = COL_W'(P_IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]   LAST_RCOL  = COL_W'(P_IMG_WIDTH - 3);
    localparam logic [P_CNT_W-1:0] FILL_START = P_CNT_W'(3 * P_IMG_WIDTH);
    localparam logic [P_CNT_W-1:0] LINE_LEN   = P_CNT_W'(P_IMG_WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         wsel_q, wsel_d;
    logic [1:0]         rsel_q, rsel_d;
    logic [COL_W-1:0]   wcol_q, wcol_d;
    logic [COL_W-1:0]   rcol_q, rcol_d;
    logic [P_CNT_W-1:0] fill_q, fill_d;
    logic [71:0]        win_q, win_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic               line_release_c;

    // Line storage; contents are never reset.
    logic [7:0]         buf_q [NBUF][P_IMG_WIDTH];

    // Pixels presented during reset are dropped.
    assign accept_c = i_pixel_data_valid & ~i_rst;

    // Line storage write port.
    always_ff @(posedge i_clk) begin
        if (accept_c) begin
            buf_q[wsel_q][wcol_q] <= i_pixel_data;
        end
    end

    // Write pointer: column advance, buffer rotation at end of line.
    always_comb begin
        wcol_d = wcol_q;
        wsel_d = wsel_q;
        if (accept_c) begin
            if (wcol_q == LAST_WCOL) begin
                wcol_d = '0;
                wsel_d = 2'(wsel_q + 2'd1);
            end else begin
                wcol_d = COL_W'(wcol_q + COL_W'(1));
            end
        end
    end

    // Read FSM: sweep one output line, then free the oldest buffer.
    always_comb begin
        state_d        = state_q;
        rcol_d         = rcol_q;
        rsel_d         = rsel_q;
        win_d          = win_q;
        valid_d        = 1'b0;
        done_d         = 1'b0;
        line_release_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                rcol_d = '0;
                if (fill_q >= FILL_START) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                valid_d = 1'b1;
                // Rows rsel..rsel+2 (oldest to newest), cols rcol..rcol+2.
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        win_d[8*(3*r+c) +: 8] =
                            buf_q[2'(rsel_q + 2'(r))][COL_W'(rcol_q + COL_W'(c))];
                    end
                end
                if (rcol_q == LAST_RCOL) begin
                    state_d        = S_IDLE;
                    rcol_d         = '0;
                    rsel_d         = 2'(rsel_q + 2'd1);
                    done_d         = 1'b1;
                    line_release_c = 1'b1;
                end else begin
                    rcol_d = COL_W'(rcol_q + COL_W'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fill level: an accept and a release in the same cycle both apply.
    always_comb begin
        fill_d = P_CNT_W'(fill_q + P_CNT_W'(accept_c)
                          - (line_release_c ? LINE_LEN : '0));
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            wsel_q  <= '0;
            wcol_q  <= '0;
            rsel_q  <= '0;
            rcol_q  <= '0;
            fill_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wsel_q  <= wsel_d;
            wcol_q  <= wcol_d;
            rsel_q  <= rsel_d;
            rcol_q  <= rcol_d;
            fill_q  <= fill_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_window_data  = win_q;
    assign o_window_valid = valid_q;
    assign o_line_done    = done_q;
    assign o_fill_level   = fill_q;

endmodule

// File: tb/tb_line_buffer_window.sv
// tb_line_buffer_window: W=8 bench for line_buffer_window. A pixel-queue model
// predicts valid/line-done/fill/window every cycle; literal expectations pin
// first-window latency, line length, rotation, reset abort and the
// simultaneous accept/release case.
module tb_line_buffer_window;

    localparam int          W  = 8;
    localparam int unsigned CW = $clog2(4 * W + 1);

    logic          clk = 1'b0;
    logic          i_rst;
    logic [7:0]    i_pixel_data;
    logic          i_pixel_data_valid;
    logic [71:0]   o_window_data;
    logic          o_window_valid;
    logic          o_line_done;
    logic [CW-1:0] o_fill_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_buffer_window #(
        .P_IMG_WIDTH(W)
    ) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_pixel_data      (i_pixel_data),
        .i_pixel_data_valid(i_pixel_data_valid),
        .o_window_data     (o_window_data),
        .o_window_valid    (o_window_valid),
        .o_line_done       (o_line_done),
        .o_fill_level      (o_fill_level)
    );

    function automatic void chk(input string name, input logic [71:0] act,
                                input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]  pix[$];        // every pixel accepted since reset, raster order
    int          cyc = 0;
    int          m_line;        // output line index == top image line
    int          m_rcol;
    int          m_fill;
    int          m_rel;
    bit          m_reading;
    bit          m_ok = 1'b0;
    logic [71:0] exp_data;
    bit          exp_valid, exp_done, exp_rst;

    function automatic logic [71:0] model_win(input int line, input int c);
        logic [71:0] w;
        int idx;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int cc = 0; cc < 3; cc++) begin
                idx = (line + r) * W + c + cc;
                w[8*(3*r+cc) +: 8] = (idx < pix.size()) ? pix[idx] : 8'hEE;
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (i_rst) begin
            pix.delete();
            m_line    = 0;
            m_rcol    = 0;
            m_fill    = 0;
            m_reading = 1'b0;
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            exp_data  = '0;
            exp_rst   = 1'b1;
            m_ok      = 1'b1;
        end else begin
            exp_rst   = 1'b0;
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            m_rel     = 0;
            if (m_reading) begin
                exp_valid = 1'b1;
                exp_data  = model_win(m_line, m_rcol);
                if (m_rcol == W - 3) begin
                    exp_done  = 1'b1;
                    m_rel     = 1;
                    m_reading = 1'b0;
                    m_line++;
                    m_rcol    = 0;
                end else begin
                    m_rcol++;
                end
            end else if (m_fill >= 3 * W) begin
                m_reading = 1'b1;
            end
            if (i_pixel_data_valid) pix.push_back(i_pixel_data);
            m_fill = m_fill + (i_pixel_data_valid ? 1 : 0) - (m_rel != 0 ? W : 0);
        end
    end

    // ---------------- per-cycle compare + line statistics ----------------
    int          nlines;
    int          vcnt;
    int          line_start[16];
    int          done_at[16];
    logic [71:0] first_win[16];

    always @(negedge clk) begin
        if (m_ok) begin
            chk("valid", 72'(o_window_valid), 72'(exp_valid));
            chk("line_done", 72'(o_line_done), 72'(exp_done));
            chk("fill", 72'(o_fill_level), 72'(m_fill));
            chk("fill_bound", 72'(o_fill_level <= CW'(4 * W - 1)), 72'(1));
            if (exp_valid || exp_rst) chk("window", o_window_data, exp_data);
        end
        if (i_rst) begin
            nlines = 0;
            vcnt   = 0;
        end else begin
            if (o_window_valid === 1'b1) begin
                if (vcnt == 0 && nlines < 16) begin
                    line_start[nlines] = cyc;
                    first_win[nlines]  = o_window_data;
                end
                vcnt++;
            end
            if (o_line_done === 1'b1) begin
                if (nlines < 16) done_at[nlines] = vcnt;
                nlines++;
                vcnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] LINE5_WIN = 72'h72_71_70_62_61_60_52_51_50;
    localparam logic [71:0] LINE1_WIN = 72'h32_31_30_22_21_20_12_11_10;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input logic v, input logic [7:0] d);
        i_pixel_data_valid = v;
        i_pixel_data       = d;
        step();
    endtask

    function automatic logic [7:0] pat(input int n);
        return 8'(16 * (n / W) + n % W);
    endfunction

    task automatic do_reset();
        i_rst              = 1'b1;
        i_pixel_data_valid = 1'b0;
        i_pixel_data       = '0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    // Pixels 0..25 of the 16*line+col pattern; pixel 23 lands on edge E.
    task automatic start_frame(input string tag);
        for (int n = 0; n < 26; n++) begin
            push_px(1'b1, pat(n));
            if (n == 23 || n == 24)
                chk({tag, "_early_valid"}, 72'(o_window_valid), 72'(0));
            if (n == 25) begin
                chk({tag, "_first_valid"}, 72'(o_window_valid), 72'(1));
                chk({tag, "_first_win"}, o_window_data, FIRST_WIN);
            end
        end
    endtask

    initial begin
        int acc;
        logic v;

        do_reset();
        chk("reset_valid", 72'(o_window_valid), 72'(0));
        chk("reset_fill", 72'(o_fill_level), 72'(0));

        // Continuous 8 lines: first window, line length, rotation, period.
        start_frame("p1");
        for (int n = 26; n < 64; n++) begin
            push_px(1'b1, pat(n));
            if (n == 30) begin
                chk("p1_done_e7", 72'(o_line_done), 72'(1));
                chk("p1_fill_e7", 72'(o_fill_level), 72'(23));
            end
        end
        i_pixel_data_valid = 1'b0;
        repeat (24) step();
        chk("p1_lines", 72'(nlines), 72'(6));
        for (int l = 0; l < 6; l++) begin
            chk($sformatf("p1_len%0d", l), 72'(done_at[l]), 72'(W - 2));
            if (l > 0)
                chk($sformatf("p1_period%0d", l),
                    72'(line_start[l] - line_start[l-1]), 72'(W));
        end
        chk("p1_line5_win", first_win[5], LINE5_WIN);
        chk("p1_end_fill", 72'(o_fill_level), 72'(16));

        // Gapped random input, ~30% duty, 5 lines.
        do_reset();
        acc = 0;
        while (acc < 5 * W) begin
            v = ($urandom_range(0, 99) < 30);
            push_px(v, 8'($urandom));
            if (v) acc++;
        end
        i_pixel_data_valid = 1'b0;
        repeat (30) step();
        chk("p2_lines", 72'(nlines), 72'(3));
        chk("p2_fill", 72'(o_fill_level), 72'(16));

        // Reset on the 3rd valid cycle of a line.
        do_reset();
        start_frame("p3");
        push_px(1'b1, pat(26));
        push_px(1'b1, pat(27));
        chk("p3_third_valid", 72'(o_window_valid), 72'(1));
        chk("p3_third_done", 72'(o_line_done), 72'(0));
        i_rst              = 1'b1;
        i_pixel_data_valid = 1'b1;
        i_pixel_data       = 8'hAB;
        step();
        chk("p3_rst_valid", 72'(o_window_valid), 72'(0));
        chk("p3_rst_done", 72'(o_line_done), 72'(0));
        chk("p3_rst_fill", 72'(o_fill_level), 72'(0));
        chk("p3_rst_data", o_window_data, 72'(0));
        i_rst              = 1'b0;
        i_pixel_data_valid = 1'b0;

        // Re-stream; accept a pixel on the releasing edge E+7.
        start_frame("p4");
        repeat (4) push_px(1'b0, 8'h00);
        chk("p4_fill_pre", 72'(o_fill_level), 72'(26));
        chk("p4_done_pre", 72'(o_line_done), 72'(0));
        push_px(1'b1, pat(26));
        chk("p4_fill_rel", 72'(o_fill_level), 72'(19));
        chk("p4_done_rel", 72'(o_line_done), 72'(1));
        for (int n = 27; n < 40; n++) push_px(1'b1, pat(n));
        i_pixel_data_valid = 1'b0;
        repeat (30) step();
        chk("p4_lines", 72'(nlines), 72'(3));
        chk("p4_line1_win", first_win[1], LINE1_WIN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
